// File: rtl/regfile_wb_sched_pkg.sv
// Shared types and constants for the regfile writeback scheduler.
// Register addresses are 5 bits wide; x0 is hardwired to zero.
package regfile_wb_sched_pkg;

  typedef logic [4:0] reg_addr_t;

  localparam int        NREGS    = 32;
  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_wb_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts at ptr and returns a one-hot grant plus the winner's index.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] winner
);

  always_comb begin
    int  idx;
    logic found;
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler and scoreboard for the 32x64 integer register file.
// Optional same-cycle forwarding from the write port is enabled with WBSCHED_BYPASS_EN.
module regfile_wb_sched
  import regfile_wb_sched_pkg::*;
#(
  parameter int NSRC = 2,
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NSRC-1:0]   src_valid,
  output logic [NSRC-1:0]   src_ready,
  input  logic [NSRC*5-1:0] src_rd,
  input  logic [NSRC*XLEN-1:0] src_data,
  input  logic              issue_valid,
  input  logic [4:0]        issue_rd,
  output logic              issue_ready,
  input  logic [4:0]        rs1_addr,
  input  logic [4:0]        rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rs1_fwd_valid,
  output logic              rs2_fwd_valid,
  output logic [XLEN-1:0]   rs1_fwd_data,
  output logic [XLEN-1:0]   rs2_fwd_data,
  output logic              wr_en,
  output logic [4:0]        wr_addr,
  output logic [XLEN-1:0]   wr_data,
  output logic              err_spurious
);

  localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    winner;
  logic [NSRC-1:0]  grant;
  logic             hs;
  reg_addr_t        win_rd;
  logic [XLEN-1:0]  win_data;
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_nxt;
  logic             issue_fire;

  rr_arbiter #(.N(NSRC), .PW(PW)) u_arb (
    .req    (src_valid),
    .ptr    (rr_ptr),
    .grant  (grant),
    .winner (winner)
  );

  assign src_ready = grant;
  assign hs        = |(src_valid & grant);

  always_comb begin
    win_rd   = REG_ZERO;
    win_data = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (grant[i]) begin
        win_rd   = src_rd[5*i +: 5];
        win_data = src_data[XLEN*i +: XLEN];
      end
    end
  end

  assign issue_ready = !pending[issue_rd] || (issue_rd == REG_ZERO);
  assign issue_fire  = issue_valid && issue_ready && (issue_rd != REG_ZERO);

  // A retiring write and a new issue to the same register in one cycle leave it pending.
  always_comb begin
    pending_nxt = pending;
    if (wr_en) pending_nxt[wr_addr] = 1'b0;
    if (issue_fire) pending_nxt[issue_rd] = 1'b1;
    pending_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending      <= '0;
      rr_ptr       <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= REG_ZERO;
      wr_data      <= '0;
      err_spurious <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (hs) begin
        rr_ptr  <= (winner == PW'(NSRC - 1)) ? '0 : winner + PW'(1);
        wr_en   <= (win_rd != REG_ZERO);
        wr_addr <= win_rd;
        wr_data <= win_data;
        if (win_rd != REG_ZERO && !pending[win_rd]) err_spurious <= 1'b1;
      end else begin
        wr_en <= 1'b0;
      end
    end
  end

`ifdef WBSCHED_BYPASS_EN
  logic rs1_hit, rs2_hit;

  assign rs1_hit       = wr_en && (wr_addr == rs1_addr) && (rs1_addr != REG_ZERO);
  assign rs2_hit       = wr_en && (wr_addr == rs2_addr) && (rs2_addr != REG_ZERO);
  assign rs1_busy      = pending[rs1_addr] && (rs1_addr != REG_ZERO) && !rs1_hit;
  assign rs2_busy      = pending[rs2_addr] && (rs2_addr != REG_ZERO) && !rs2_hit;
  assign rs1_fwd_valid = rs1_hit;
  assign rs2_fwd_valid = rs2_hit;
  assign rs1_fwd_data  = rs1_hit ? wr_data : '0;
  assign rs2_fwd_data  = rs2_hit ? wr_data : '0;
`else
  // Without forwarding, decode waits until the regfile holds the value.
  assign rs1_busy      = pending[rs1_addr] && (rs1_addr != REG_ZERO);
  assign rs2_busy      = pending[rs2_addr] && (rs2_addr != REG_ZERO);
  assign rs1_fwd_valid = 1'b0;
  assign rs2_fwd_valid = 1'b0;
  assign rs1_fwd_data  = '0;
  assign rs2_fwd_data  = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed self-checking bench for regfile_wb_sched (NSRC=2, XLEN=64).
// Expectations follow WBSCHED_BYPASS_EN when it is defined for the build.
module tb_regfile_wb_sched;

  import regfile_wb_sched_pkg::*;

`ifdef WBSCHED_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   src_valid;
  logic [1:0]   src_ready;
  logic [9:0]   src_rd;
  logic [127:0] src_data;
  logic         issue_valid;
  logic [4:0]   issue_rd;
  logic         issue_ready;
  logic [4:0]   rs1_addr, rs2_addr;
  logic         rs1_busy, rs2_busy;
  logic         rs1_fwd_valid, rs2_fwd_valid;
  logic [63:0]  rs1_fwd_data, rs2_fwd_data;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [63:0]  wr_data;
  logic         err_spurious;

  int checkCount = 0;
  int passCount  = 0;

  regfile_wb_sched #(.NSRC(2), .XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_valid(src_valid), .src_ready(src_ready), .src_rd(src_rd), .src_data(src_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_fwd_valid(rs1_fwd_valid), .rs2_fwd_valid(rs2_fwd_valid),
    .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Drives one cycle of inputs at the falling edge, then lets logic settle.
  task automatic applyStimulus(input logic iv, input logic [4:0] ird, input logic [1:0] sv,
                               input logic [4:0] rd0, input logic [63:0] d0,
                               input logic [4:0] rd1, input logic [63:0] d1,
                               input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    issue_valid = iv;
    issue_rd    = ird;
    src_valid   = sv;
    src_rd      = {rd1, rd0};
    src_data    = {d1, d0};
    rs1_addr    = r1;
    rs2_addr    = r2;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    issue_valid = 1'b0; issue_rd = 5'd5; src_valid = 2'b00;
    src_rd = '0; src_data = '0; rs1_addr = '0; rs2_addr = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_wr_en", {63'd0, wr_en}, 64'd0);
    checkOutput("rst_wr_addr", {59'd0, wr_addr}, 64'd0);
    checkOutput("rst_wr_data", wr_data, 64'd0);
    checkOutput("rst_err", {63'd0, err_spurious}, 64'd0);
    checkOutput("rst_issue_ready", {63'd0, issue_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Issue x5, write it back from src0, then observe the pending bit clear
    applyStimulus(1'b1, 5'd5, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 5'd5, 5'd0);
    checkOutput("t2_issue_ready", {63'd0, issue_ready}, 64'd1);
    applyStimulus(1'b0, 5'd0, 2'b01, 5'd5, 64'hAA, 5'd0, 64'h0, 5'd5, 5'd0);
    checkOutput("t2_src_ready", {62'd0, src_ready}, 64'd1);
    checkOutput("t2_rs1_busy_pend", {63'd0, rs1_busy}, 64'd1);
    applyStimulus(1'b0, 5'd0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 5'd5, 5'd0);
    checkOutput("t2_wr_en", {63'd0, wr_en}, 64'd1);
    checkOutput("t2_wr_addr", {59'd0, wr_addr}, 64'd5);
    checkOutput("t2_wr_data", wr_data, 64'hAA);
    checkOutput("t2_rs1_busy_wr", {63'd0, rs1_busy}, BYP ? 64'd0 : 64'd1);
    checkOutput("t2_rs1_fwd_valid", {63'd0, rs1_fwd_valid}, BYP ? 64'd1 : 64'd0);
    applyStimulus(1'b0, 5'd0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 5'd5, 5'd0);
    checkOutput("t2_rs1_busy_after", {63'd0, rs1_busy}, 64'd0);
    checkOutput("t2_wr_en_off", {63'd0, wr_en}, 64'd0);
    checkOutput("t2_err", {63'd0, err_spurious}, 64'd0);

    // WAW block on x7; x0 issue always accepted and never marked pending
    applyStimulus(1'b1, 5'd7, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 5'd0, 5'd0);
    applyStimulus(1'b1, 5'd7, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 5'd7, 5'd0);
    checkOutput("t4_issue_ready_waw", {63'd0, issue_ready}, 64'd0);
    checkOutput("t4_rs1_busy7", {63'd0, rs1_busy}, 64'd1);
    applyStimulus(1'b1, 5'd0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 5'd7, 5'd0);
    checkOutput("t4_issue_ready_x0", {63'd0, issue_ready}, 64'd1);
    applyStimulus(1'b0, 5'd0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 5'd0, 5'd0);
    checkOutput("t4_rs1_busy_x0", {63'd0, rs1_busy}, 64'd0);

    // Spurious write to x9 from src1 (rr_ptr is 1 here)
    applyStimulus(1'b0, 5'd0, 2'b10, 5'd0, 64'h0, 5'd9, 64'h99, 5'd0, 5'd0);
    checkOutput("t5_src_ready", {62'd0, src_ready}, 64'd2);
    applyStimulus(1'b0, 5'd0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 5'd0, 5'd0);
    checkOutput("t5_wr_en", {63'd0, wr_en}, 64'd1);
    checkOutput("t5_wr_addr", {59'd0, wr_addr}, 64'd9);
    checkOutput("t5_wr_data", wr_data, 64'h99);
    checkOutput("t5_err_set", {63'd0, err_spurious}, 64'd1);
    applyStimulus(1'b0, 5'd0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 5'd0, 5'd0);
    checkOutput("t5_err_sticky", {63'd0, err_spurious}, 64'd1);

    // Two sources valid continuously: grants alternate starting at rr_ptr=0
    applyStimulus(1'b1, 5'd1, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 5'd0, 5'd0);
    applyStimulus(1'b1, 5'd2, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 5'd0, 5'd0);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 5'd0, 2'b11, 5'd1, 64'h11, 5'd2, 64'h22, 5'd0, 5'd0);
      checkOutput($sformatf("t3_grant%0d", c), {62'd0, src_ready}, (c % 2 == 0) ? 64'd1 : 64'd2);
      checkOutput($sformatf("t3_wr_en%0d", c), {63'd0, wr_en}, (c == 0) ? 64'd0 : 64'd1);
      if (c != 0)
        checkOutput($sformatf("t3_wr_addr%0d", c), {59'd0, wr_addr}, (c % 2 == 1) ? 64'd1 : 64'd2);
    end
    applyStimulus(1'b0, 5'd0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 5'd0, 5'd0);
    checkOutput("t3_tail_addr", {59'd0, wr_addr}, 64'd2);
    checkOutput("t3_tail_data", wr_data, 64'h22);
    applyStimulus(1'b0, 5'd0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 5'd0, 5'd0);
    checkOutput("t3_idle_wr_en", {63'd0, wr_en}, 64'd0);
    checkOutput("t3_hold_addr", {59'd0, wr_addr}, 64'd2);

    // Forwarding on rs2 during the x3 write cycle
    applyStimulus(1'b1, 5'd3, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 5'd0, 5'd3);
    applyStimulus(1'b0, 5'd0, 2'b01, 5'd3, 64'h1234, 5'd0, 64'h0, 5'd0, 5'd3);
    checkOutput("t6_src_ready", {62'd0, src_ready}, 64'd1);
    checkOutput("t6_rs2_busy_pend", {63'd0, rs2_busy}, 64'd1);
    checkOutput("t6_rs2_fwd_off", {63'd0, rs2_fwd_valid}, 64'd0);
    applyStimulus(1'b0, 5'd0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 5'd0, 5'd3);
    checkOutput("t6_wr_addr", {59'd0, wr_addr}, 64'd3);
    checkOutput("t6_rs2_fwd_valid", {63'd0, rs2_fwd_valid}, BYP ? 64'd1 : 64'd0);
    checkOutput("t6_rs2_fwd_data", rs2_fwd_data, BYP ? 64'h1234 : 64'h0);
    checkOutput("t6_rs2_busy_wr", {63'd0, rs2_busy}, BYP ? 64'd0 : 64'd1);
    checkOutput("t6_rs1_fwd_valid", {63'd0, rs1_fwd_valid}, 64'd0);
    applyStimulus(1'b0, 5'd0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 5'd0, 5'd3);
    checkOutput("t6_rs2_busy_after", {63'd0, rs2_busy}, 64'd0);

    // Reset in the middle of traffic while x7 is still pending
    applyStimulus(1'b1, 5'd7, 2'b11, 5'd1, 64'h5, 5'd2, 64'h6, 5'd7, 5'd0);
    checkOutput("t1_pre_busy", {63'd0, rs1_busy}, 64'd1);
    checkOutput("t1_pre_issue_ready", {63'd0, issue_ready}, 64'd0);
    applyStimulus(1'b1, 5'd7, 2'b11, 5'd1, 64'h5, 5'd2, 64'h6, 5'd7, 5'd0);
    checkOutput("t1_pre_wr_en", {63'd0, wr_en}, 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t1_wr_en", {63'd0, wr_en}, 64'd0);
    checkOutput("t1_rs1_busy", {63'd0, rs1_busy}, 64'd0);
    checkOutput("t1_issue_ready", {63'd0, issue_ready}, 64'd1);
    checkOutput("t1_err", {63'd0, err_spurious}, 64'd0);
    applyStimulus(1'b0, 5'd0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 5'd7, 5'd0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 5'd0, 2'b00, 5'd0, 64'h0, 5'd0, 64'h0, 5'd7, 5'd0);
    checkOutput("t1_post_wr_en", {63'd0, wr_en}, 64'd0);
    checkOutput("t1_post_busy", {63'd0, rs1_busy}, 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
